// File: rtl/rtc_pkg.sv
// rtc_pkg: shared widths, calendar limits, byte-index and state enums, and
// the snapshot payload for the rtc timekeeper and its readers.
package rtc_pkg;

    localparam int unsigned SEC_W   = 6;
    localparam int unsigned MIN_W   = 6;
    localparam int unsigned HOUR_W  = 5;
    localparam int unsigned DATE_W  = 5;
    localparam int unsigned MONTH_W = 4;
    localparam int unsigned BIN_W   = 6;
    localparam int unsigned BCD_W   = 8;
    localparam int unsigned IDX_W   = 3;

    localparam int unsigned SEC_MAX   = 59;
    localparam int unsigned MIN_MAX   = 59;
    localparam int unsigned HOUR_MAX  = 23;
    localparam int unsigned MONTH_MAX = 12;

    typedef enum logic [IDX_W-1:0] {
        IDX_HOUR   = 3'd0,
        IDX_MINUTE = 3'd1,
        IDX_SEC    = 3'd2,
        IDX_DATE   = 3'd3,
        IDX_MONTH  = 3'd4
    } idx_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    typedef struct packed {
        logic [HOUR_W-1:0]  hour;
        logic [MIN_W-1:0]   minute;
        logic [SEC_W-1:0]   sec;
        logic [DATE_W-1:0]  date;
        logic [MONTH_W-1:0] month;
    } snap_t;

    // True when any field of the snapshot lies outside its calendar range.
    function automatic logic snap_out_of_range(input snap_t s);
        return (32'(s.sec)    > SEC_MAX)   ||
               (32'(s.minute) > MIN_MAX)   ||
               (32'(s.hour)   > HOUR_MAX)  ||
               (s.month == '0)             ||
               (32'(s.month)  > MONTH_MAX) ||
               (s.date  == '0);
    endfunction

endpackage

// File: rtl/rtc_bin2bcd.sv
// rtc_bin2bcd: combinational 6-bit binary (0-63) to packed two-digit BCD.
// Ports: bin - binary value; bcd_c - tens in [7:4], ones in [3:0].
module rtc_bin2bcd
    import rtc_pkg::*;
(
    input  logic [BIN_W-1:0] bin,
    output logic [BCD_W-1:0] bcd_c
);

    logic [2:0]       tens;
    logic [BIN_W-1:0] base;
    logic [3:0]       ones;

    // Largest multiple of ten not above bin; the remainder is the ones digit.
    always_comb begin
        tens = 3'd0;
        base = 6'd0;
        if (bin >= 6'd60) begin
            tens = 3'd6;
            base = 6'd60;
        end else if (bin >= 6'd50) begin
            tens = 3'd5;
            base = 6'd50;
        end else if (bin >= 6'd40) begin
            tens = 3'd4;
            base = 6'd40;
        end else if (bin >= 6'd30) begin
            tens = 3'd3;
            base = 6'd30;
        end else if (bin >= 6'd20) begin
            tens = 3'd2;
            base = 6'd20;
        end else if (bin >= 6'd10) begin
            tens = 3'd1;
            base = 6'd10;
        end
        ones  = 4'(bin - base);
        bcd_c = {1'b0, tens, ones};
    end

endmodule

// File: rtl/rtc_bcd_reader.sv
// rtc_bcd_reader: on req, snapshots the rtc time fields and streams them as
// five packed-BCD bytes (hour, minute, sec, date, month) over valid/ready.
// Ports: clk, rst (sync, active-high); sec/minute/hour/date/month live fields;
// req frame request (IDLE only); out_ready downstream accept;
// out_valid/out_data/out_last byte stream; busy frame in progress;
// range_err snapshot has an out-of-range field (held for the frame).
module rtc_bcd_reader
    import rtc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [SEC_W-1:0]   sec,
    input  logic [MIN_W-1:0]   minute,
    input  logic [HOUR_W-1:0]  hour,
    input  logic [DATE_W-1:0]  date,
    input  logic [MONTH_W-1:0] month,
    input  logic               req,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [BCD_W-1:0]   out_data,
    output logic               out_last,
    output logic               busy,
    output logic               range_err
);

    state_e           state_q, state_d;
    idx_e             idx_q, idx_d;
    snap_t            snap_q, snap_d;
    snap_t            live;
    logic [BCD_W-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [BIN_W-1:0] conv_in;
    logic [BCD_W-1:0] conv_out_c;

    always_comb begin
        live.hour   = hour;
        live.minute = minute;
        live.sec    = sec;
        live.date   = date;
        live.month  = month;
    end

    // Converter input: live hour while idle (byte 0 loads on the req edge),
    // otherwise the snapshot field of the byte that loads on the next accept.
    always_comb begin
        conv_in = 6'(hour);
        if (state_q == ST_SEND) begin
            unique case (idx_q)
                IDX_HOUR:   conv_in = 6'(snap_q.minute);
                IDX_MINUTE: conv_in = 6'(snap_q.sec);
                IDX_SEC:    conv_in = 6'(snap_q.date);
                IDX_DATE:   conv_in = 6'(snap_q.month);
                default:    conv_in = 6'(snap_q.hour);
            endcase
        end
    end

    rtc_bin2bcd u_bin2bcd (
        .bin   (conv_in),
        .bcd_c (conv_out_c)
    );

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    snap_d  = live;
                    data_d  = conv_out_c;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    last_d  = 1'b0;
                    idx_d   = IDX_HOUR;
                    err_d   = snap_out_of_range(live);
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (valid_q && out_ready) begin
                    if (idx_q == IDX_MONTH) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        last_d  = 1'b0;
                        idx_d   = IDX_HOUR;
                        state_d = ST_IDLE;
                    end else begin
                        idx_d  = idx_e'(idx_q + 3'd1);
                        data_d = conv_out_c;
                        last_d = (idx_q == IDX_DATE);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= IDX_HOUR;
            snap_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
    assign busy      = busy_q;
    assign range_err = err_q;

endmodule

// File: doc/rtc_bcd_reader.md
# rtc_bcd_reader

Read-side companion to the `rtc` timekeeper. On a request it atomically snapshots the time fields and streams them out as five packed-BCD bytes over a valid/ready byte interface, for use by a display driver or host serial link. It also reports fields that are out of calendar range. It never writes the timekeeper.

## Interface
Parameters:
- none; field widths and limits are fixed constants in `rtc_pkg`.

Ports:
- `clk` in 1: system clock, the same clock that drives `rtc`.
- `rst` in 1: reset; one clock; synchronous, active-high.
- `sec` in 6: binary seconds, 0–59.
- `minute` in 6: binary minutes, 0–59.
- `hour` in 5: binary hours, 0–23.
- `date` in 5: binary day of month.
- `month` in 4: binary month, 1–12.
- `req` in 1: frame request; sampled only in IDLE.
- `out_ready` in 1: downstream accepts `out_data` this cycle.
- `out_valid` out 1: `out_data` holds a valid byte.
- `out_data` out 8: packed BCD byte, tens in [7:4], ones in [3:0].
- `out_last` out 1: the current byte is the final byte of the frame (month).
- `busy` out 1: a frame is in progress.
- `range_err` out 1: at least one snapshot field is out of range; held for the whole frame.

## Operation
- States: IDLE and SEND.
- IDLE:
  - Edge with `req`=1 captures all five fields into snapshot registers.
  - Same edge loads byte 0 into `out_data`, sets `out_valid`=1, `busy`=1, index=0, computes `range_err`, and moves to SEND.
- SEND:
  - `out_data`, `out_last` and `range_err` hold stable while `out_valid`=1 and `out_ready`=0.
  - Each edge with `out_valid`&`out_ready` advances the index and loads the next byte.
  - Acceptance of index 4 returns to IDLE with `out_valid`=0, `busy`=0, `out_last`=0.
  - `req` is ignored in SEND, including on the final accept edge. A new frame needs `req` sampled in IDLE.
- Byte order:
  - index 0 = hour, 1 = minute, 2 = sec, 3 = date, 4 = month.
  - `out_last`=1 only at index 4.
- BCD conversion:
  - Input v is 0–63: tens = largest t in 0..6 with v ≥ 10·t; ones = v − 10·t.
  - Out-of-range values still convert, e.g. sec 61 → 0x61.
- `range_err` = (sec>59) | (minute>59) | (hour>23) | (month==0) | (month>12) | (date==0), evaluated on the snapshot.
- The live inputs may change during SEND. The frame always reflects the capture edge, which prevents tearing across a seconds rollover.
- Reset values: `out_valid`=0, `out_last`=0, `busy`=0, `range_err`=0, `out_data`=0x00, state=IDLE, index=0, snapshot=0.
- Reset in mid-frame aborts the frame immediately. No further bytes are sent.

## Timing
- Latency: `req` sampled at edge N; `out_valid`=1 from the cycle after edge N.
- With `out_ready` held at 1, one byte is accepted per cycle. The frame takes 5 cycles, and `busy` drops in the cycle after the 5th accept edge.
- Minimum spacing from one request edge to the next accepted request edge is 6 cycles.
- `busy` equals `out_valid` in every cycle.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- `rtc_pkg`:
  - width constants `SEC_W`=6, `MIN_W`=6, `HOUR_W`=5, `DATE_W`=5, `MONTH_W`=4;
  - limit constants `SEC_MAX`=59, `MIN_MAX`=59, `HOUR_MAX`=23, `MONTH_MAX`=12;
  - byte-index enum `IDX_HOUR`..`IDX_MONTH`;
  - state enum `ST_IDLE`/`ST_SEND`.
- Sub-module `rtc_bin2bcd`: combinational, 6-bit binary in, 8-bit packed BCD out. It is instantiated once and fed by the index-selected snapshot field; in IDLE it is fed by the live `hour` input.

## Test plan
- Basic frame: inputs 23:59:58, date 31, month 12, `out_ready`=1, one-cycle `req` → bytes 0x23, 0x59, 0x58, 0x31, 0x12 on consecutive cycles, `out_last` only on 0x12, `range_err`=0.
- Backpressure: same inputs, `out_ready` low for 3 cycles at index 1 → 0x59 holds stable, no byte is skipped or duplicated, frame completes in 8 cycles.
- Snapshot: `req` at 12:34:59, then inputs change to 12:35:00 during SEND → stream reads 0x12, 0x34, 0x59.
- Range error: sec=61, month=0, date=5 → `range_err`=1 for the whole frame; sec byte = 0x61, month byte = 0x00.
- Request handling: `req` held high continuously → new frames start only from IDLE, spaced 6 cycles apart with `out_ready`=1; `req` during SEND has no effect.
- Reset at index 2 → next cycle `out_valid`=0, `busy`=0, `out_data`=0x00; a following `req` starts a fresh frame at hour.
